fifo_arb: RTL

FIFO_ARB -- requirements
Module: fifo_arb

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_arb_rr_pick.sv | 35 +++
 rtl/fifo_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// fifo_arb_pkg : shared state encoding and sizing helpers for fifo_arb
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int BURST_CNT_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_arb_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first valid index after i_last
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_last,
    input  logic [NUM_REQ-1:0] i_excl,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    // Walk from farthest to nearest so the nearest candidate overwrites last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_valid[(int'(i_last) + k) % NUM_REQ] &&
                !i_excl[(int'(i_last) + k) % NUM_REQ]) begin
                o_idx   = IDX_W'((int'(i_last) + k) % NUM_REQ);
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_arb.sv
// ============================================================================
// fifo_arb : round-robin burst arbiter funnelling requesters into one FIFO port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  BURST_MAX  = 4,
    localparam int IDX_W      = idx_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_afull,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_d,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    localparam logic [BURST_CNT_W-1:0] c_BURST_MAX = BURST_CNT_W'(BURST_MAX);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       w_grant_nxt;
    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       w_last_nxt;
    logic [BURST_CNT_W-1:0] r_cnt;
    logic [BURST_CNT_W-1:0] w_cnt_nxt;
    logic [BURST_CNT_W-1:0] w_cnt_inc;
    logic                   r_we;
    logic [DATA_WIDTH-1:0]  r_d;

    logic [DATA_WIDTH-1:0]  w_data [NUM_REQ];
    logic [NUM_REQ-1:0]     w_hold_oh;
    logic [NUM_REQ-1:0]     w_pick_excl;
    logic [IDX_W-1:0]       w_pick_last;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_found;
    logic                   w_space;
    logic                   w_xfer;
    logic                   w_release;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_hold_oh          = '0;
        w_hold_oh[r_grant] = 1'b1;
    end

    // A write already in flight consumes the last free entry.
    assign w_space   = !fifo_full && !(fifo_afull && r_we);
    assign w_xfer    = (r_state == GRANT) && w_space && req_valid[r_grant];
    assign w_cnt_inc = r_cnt + BURST_CNT_W'(1);
    assign w_release = (r_state == GRANT) &&
                       (!req_valid[r_grant] || (w_xfer && (w_cnt_inc == c_BURST_MAX)));

    // Holder is only eligible again when nobody else is asking.
    assign w_pick_last = (r_state == GRANT) ? r_grant : r_last;
    assign w_pick_excl = ((r_state == GRANT) && |(req_valid & ~w_hold_oh)) ? w_hold_oh : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_last  (w_pick_last),
        .i_excl  (w_pick_excl),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_last_nxt = r_grant;
                    w_cnt_nxt  = '0;
                    if (w_pick_found) begin
                        w_grant_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_xfer;
            if (w_xfer) begin
                r_d <= w_data[r_grant];
            end
        end
    end

    assign req_ready = ((r_state == GRANT) && w_space) ? w_hold_oh : '0;
    assign fifo_we   = r_we;
    assign fifo_d    = r_d;
    assign grant_id  = r_grant;
    assign busy      = (r_state == GRANT);

endmodule

`default_nettype wire
